// File: rtl/fetch_unit.sv
// Instruction fetch: program counter, instruction-memory read issue and an epoch-tagged prefetch FIFO feeding decode.
// Define FETCH_RESET_FROM_MEM_EN to boot the PC from {M[0], M[1]} instead of RESET_VECTOR.
module fetch_unit #(
  parameter int                    ADDR_WIDTH   = 32,
  parameter int                    INSTR_WIDTH  = 16,
  parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = ADDR_WIDTH'('h20),
  parameter int                    FIFO_DEPTH   = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  output logic                   imem_rd,
  output logic [ADDR_WIDTH-1:0]  imem_addr,
  input  logic [INSTR_WIDTH-1:0] imem_rdata,
  input  logic                   redirect_valid,
  input  logic [ADDR_WIDTH-1:0]  redirect_pc,
  output logic                   instr_valid,
  input  logic                   instr_ready,
  output logic [INSTR_WIDTH-1:0] instr,
  output logic [ADDR_WIDTH-1:0]  instr_pc
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int OCC_W = PTR_W + 2;

  logic [ADDR_WIDTH-1:0]  fetch_pc;
  logic                   inflight;
  logic [ADDR_WIDTH-1:0]  inflight_pc;
  logic                   inflight_epoch;
  logic                   epoch;

  logic [INSTR_WIDTH-1:0] fifo_instr [FIFO_DEPTH];
  logic [ADDR_WIDTH-1:0]  fifo_pc    [FIFO_DEPTH];
  logic [PTR_W-1:0]       rd_ptr;
  logic [PTR_W-1:0]       wr_ptr;
  logic [CNT_W-1:0]       count;

  logic                   run;
  logic                   load_issue;
  logic [ADDR_WIDTH-1:0]  load_addr;
  logic                   load_done;
  logic [ADDR_WIDTH-1:0]  load_pc;

  logic                   flush;
  logic                   pop;
  logic                   push;
  logic                   issue;
  logic [OCC_W-1:0]       occ;

`ifdef FETCH_RESET_FROM_MEM_EN
  typedef enum logic [1:0] {LOAD_HI, LOAD_LO, RUN} state_t;

  state_t                 state;
  logic [INSTR_WIDTH-1:0] boot_hi;
  logic                   hi_return;

  // LOAD_LO spans two cycles: M[0] returns (and M[1] is requested), then M[1] returns.
  assign hi_return  = (state == LOAD_LO) && inflight && (inflight_pc == '0);
  assign run        = (state == RUN);
  assign load_issue = (state == LOAD_HI) || hi_return;
  assign load_addr  = (state == LOAD_LO) ? ADDR_WIDTH'(1) : '0;
  assign load_done  = (state == LOAD_LO) && inflight && (inflight_pc != '0);
  assign load_pc    = ADDR_WIDTH'({boot_hi, imem_rdata});

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= LOAD_HI;
      boot_hi <= '0;
    end else begin
      case (state)
        LOAD_HI: state <= LOAD_LO;
        LOAD_LO: begin
          if (hi_return) boot_hi <= imem_rdata;
          if (load_done) state <= RUN;
        end
        default: ;
      endcase
    end
  end
`else
  assign run        = 1'b1;
  assign load_issue = 1'b0;
  assign load_addr  = '0;
  assign load_done  = 1'b0;
  assign load_pc    = '0;
`endif

  assign flush       = run && redirect_valid;
  assign instr_valid = run && !redirect_valid && (count != '0);
  assign pop         = instr_valid && instr_ready;
  assign push        = run && !flush && inflight && (inflight_epoch == epoch);

  // An in-flight read already owns a FIFO slot; a same-cycle pop frees one.
  assign occ   = OCC_W'(count) + OCC_W'(inflight) - OCC_W'(pop);
  assign issue = run && !redirect_valid && (occ < OCC_W'(FIFO_DEPTH));

  assign imem_rd   = rst && (issue || load_issue);
  assign imem_addr = !rst      ? '0 :
                     issue      ? fetch_pc :
                     load_issue ? load_addr : '0;

  assign instr    = fifo_instr[rd_ptr];
  assign instr_pc = fifo_pc[rd_ptr];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_pc       <= RESET_VECTOR;
      inflight       <= 1'b0;
      inflight_pc    <= '0;
      inflight_epoch <= 1'b0;
      epoch          <= 1'b0;
      rd_ptr         <= '0;
      wr_ptr         <= '0;
      count          <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_instr[i] <= '0;
        fifo_pc[i]    <= '0;
      end
    end else begin
      inflight       <= issue || load_issue;
      inflight_pc    <= issue ? fetch_pc : load_addr;
      inflight_epoch <= epoch;
      if (flush) begin
        epoch    <= ~epoch;
        fetch_pc <= redirect_pc;
        count    <= '0;
        wr_ptr   <= rd_ptr;
      end else begin
        if (load_done)
          fetch_pc <= load_pc;
        else if (issue)
          fetch_pc <= fetch_pc + ADDR_WIDTH'(1);
        if (push) begin
          fifo_instr[wr_ptr] <= imem_rdata;
          fifo_pc[wr_ptr]    <= inflight_pc;
          wr_ptr             <= wr_ptr + PTR_W'(1);
        end
        if (pop)
          rd_ptr <= rd_ptr + PTR_W'(1);
        count <= count + CNT_W'(push) - CNT_W'(pop);
      end
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed-then-random bench for fetch_unit: a synchronous memory model plus an in-order
// PC/instruction scoreboard that restarts at every redirect and at reset.
module tb_fetch_unit;

`ifdef FETCH_RESET_FROM_MEM_EN
  localparam logic [31:0] START     = 32'h40;
  localparam logic [31:0] BOOT_ADDR = 32'h0;
  localparam int          FIRST_LAT = 5;
`else
  localparam logic [31:0] START     = 32'h20;
  localparam logic [31:0] BOOT_ADDR = 32'h20;
  localparam int          FIRST_LAT = 2;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_rd;
  logic [31:0] imem_addr;
  logic [15:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic [15:0] instr;
  logic [31:0] instr_pc;

  int          checks = 0;
  int          errors = 0;
  int          nacc   = 0;
  int          rd_cnt = 0;
  logic [31:0] exp_pc;
  logic        saw_zero = 1'b0;

  fetch_unit #(
    .ADDR_WIDTH  (32),
    .INSTR_WIDTH (16),
    .RESET_VECTOR(32'h20),
    .FIFO_DEPTH  (4)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .imem_rd       (imem_rd),
    .imem_addr     (imem_addr),
    .imem_rdata    (imem_rdata),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .instr_valid   (instr_valid),
    .instr_ready   (instr_ready),
    .instr         (instr),
    .instr_pc      (instr_pc)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] memf(input logic [31:0] a);
    if (a == 32'h0) return 16'h0000;
    if (a == 32'h1) return 16'h0040;
    if (a >= 32'h20 && a <= 32'h27) return 16'hA000 + 16'(a - 32'h20);
    return a[15:0] ^ {a[31:24], a[23:16]} ^ 16'h5AC3;
  endfunction

  always @(posedge clk) if (imem_rd) imem_rdata <= memf(imem_addr);

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Apply inputs on the falling edge, sample 1 time unit later, and score any handshake.
  task automatic step(input logic rv, input logic [31:0] rpc, input logic rdy);
    @(negedge clk);
    redirect_valid = rv;
    redirect_pc    = rpc;
    instr_ready    = rdy;
    #1;
    if (imem_rd) rd_cnt++;
    if (rv) chk("redirect_hides_head", 64'(instr_valid), 64'(0));
    if (instr_valid && instr_ready) begin
      chk("head_pc", 64'(instr_pc), 64'(exp_pc));
      chk("head_instr", 64'(instr), 64'(memf(exp_pc)));
      if (instr_pc == 32'h0) saw_zero = 1'b1;
      exp_pc = exp_pc + 32'h1;
      nacc++;
    end
    if (rv) exp_pc = rpc;
  endtask

  task automatic release_and_start(input string tag);
    int lat;
    @(negedge clk);
    rst            = 1'b1;
    redirect_valid = 1'b0;
    instr_ready    = 1'b1;
    exp_pc         = START;
    #1;
    chk({tag, "_rd"}, 64'(imem_rd), 64'(1));
    chk({tag, "_addr"}, 64'(imem_addr), 64'(BOOT_ADDR));
    chk({tag, "_valid0"}, 64'(instr_valid), 64'(0));
    lat = 0;
    do begin
      step(1'b0, 32'h0, 1'b1);
      lat++;
    end while (!instr_valid && lat < 20);
    chk({tag, "_latency"}, 64'(lat), 64'(FIRST_LAT));
  endtask

  initial begin
    int          n0;
    logic        rv_r;
    logic [31:0] rpc_r;
    logic        rdy_r;

    rst            = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    instr_ready    = 1'b0;
    #2 rst = 1'b0;
    #1;
    chk("reset_rd", 64'(imem_rd), 64'(0));
    chk("reset_addr", 64'(imem_addr), 64'(0));
    chk("reset_valid", 64'(instr_valid), 64'(0));
    chk("reset_instr", 64'(instr), 64'(0));
    chk("reset_pc", 64'(instr_pc), 64'(0));
    repeat (2) @(negedge clk);

    // Sequential fetch with decode always ready: no bubbles once started.
    release_and_start("boot");
    for (int i = 0; i < 11; i++) begin
      step(1'b0, 32'h0, 1'b1);
      chk("stream_no_gap", 64'(instr_valid), 64'(1));
    end

    // Backpressure from a clean redirect: exactly FIFO_DEPTH reads, then stall.
    step(1'b1, 32'h300, 1'b0);
    rd_cnt = 0;
    for (int i = 0; i < 10; i++) step(1'b0, 32'h0, 1'b0);
    chk("bp_reads", 64'(rd_cnt), 64'(4));
    chk("bp_rd_idle", 64'(imem_rd), 64'(0));
    chk("bp_full_valid", 64'(instr_valid), 64'(1));
    n0 = nacc;
    for (int i = 0; i < 8; i++) step(1'b0, 32'h0, 1'b1);
    chk("drain_throughput", 64'(nacc - n0), 64'(8));
    chk("rd_before_redirect", 64'(imem_rd), 64'(1));

    // Redirect right after an issue: stale word dropped, target visible 3 cycles later.
    step(1'b1, 32'h100, 1'b1);
    step(1'b0, 32'h0, 1'b1);
    chk("redir_issue_rd", 64'(imem_rd), 64'(1));
    chk("redir_issue_addr", 64'(imem_addr), 64'(32'h100));
    chk("redir_n1_valid", 64'(instr_valid), 64'(0));
    step(1'b0, 32'h0, 1'b1);
    chk("redir_n2_valid", 64'(instr_valid), 64'(0));
    step(1'b0, 32'h0, 1'b1);
    chk("redir_n3_valid", 64'(instr_valid), 64'(1));
    chk("redir_n3_pc", 64'(instr_pc), 64'(32'h100));
    for (int i = 0; i < 4; i++) step(1'b0, 32'h0, 1'b1);

    // Redirect together with ready while full: redirect wins, no pop.
    step(1'b1, 32'h200, 1'b0);
    for (int i = 0; i < 6; i++) step(1'b0, 32'h0, 1'b0);
    chk("simul_full_valid", 64'(instr_valid), 64'(1));
    chk("simul_full_rd", 64'(imem_rd), 64'(0));
    n0 = nacc;
    step(1'b1, 32'h180, 1'b1);
    chk("simul_no_pop", 64'(nacc - n0), 64'(0));
    step(1'b0, 32'h0, 1'b0);
    chk("simul_empty", 64'(instr_valid), 64'(0));
    chk("simul_resume_rd", 64'(imem_rd), 64'(1));
    chk("simul_resume_addr", 64'(imem_addr), 64'(32'h180));
    for (int i = 0; i < 6; i++) step(1'b0, 32'h0, 1'b1);

    // PC wrap-around from the top of the address space.
    saw_zero = 1'b0;
    step(1'b1, 32'hFFFF_FFFF, 1'b1);
    for (int i = 0; i < 6; i++) step(1'b0, 32'h0, 1'b1);
    chk("wrap_to_zero", 64'(saw_zero), 64'(1));

    // Asynchronous reset between clock edges while streaming.
    @(negedge clk);
    #3 rst = 1'b0;
    #1;
    chk("async_rd", 64'(imem_rd), 64'(0));
    chk("async_addr", 64'(imem_addr), 64'(0));
    chk("async_valid", 64'(instr_valid), 64'(0));
    chk("async_instr", 64'(instr), 64'(0));
    chk("async_pc", 64'(instr_pc), 64'(0));
    release_and_start("restart");

    // Random ready / redirect traffic against the scoreboard.
    n0 = nacc;
    for (int i = 0; i < 400; i++) begin
      rv_r  = ($urandom_range(0, 19) == 0);
      rpc_r = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFFC + 32'($urandom_range(0, 3)))
                                          : ($urandom & 32'h0000_0FFF);
      rdy_r = ($urandom_range(0, 3) != 0);
      step(rv_r, rpc_r, rdy_r);
    end
    chk("random_progress", 64'((nacc - n0) > 50), 64'(1));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
